// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready skid pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/skid_lane_regs.sv
// One entry of lane storage: NUM_REG lanes of DATA_WIDTH bits with a shared
// load enable and asynchronous clear to zero.
module skid_lane_regs #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REG    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d [NUM_REG],
    output logic [DATA_WIDTH-1:0] q [NUM_REG]
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REG; k++) q[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < NUM_REG; k++) q[k] <= d[k];
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready skid stage feeding the multi-register bank.
// Define PIPE_SKID_STATS_EN to add the saturating o_stall_cnt output.
//
//  state | meaning
//  EMPTY | no entry held
//  BUSY  | head entry in main
//  FULL  | head in main, next entry in skid
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REG    = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [DATA_WIDTH-1:0]  i_data [NUM_REG],
    output logic                   o_valid,
    input  logic                   i_ready,
`ifdef PIPE_SKID_STATS_EN
    output logic [STALL_CNT_W-1:0] o_stall_cnt,
`endif
    output logic [DATA_WIDTH-1:0]  o_data [NUM_REG]
);

    skid_state_t           state_q, state_d;
    logic                  push, pop;
    logic                  main_load, skid_load, main_from_skid;
    logic [DATA_WIDTH-1:0] main_d [NUM_REG];
    logic [DATA_WIDTH-1:0] skid_q [NUM_REG];

    // Handshake outputs decode from the state register only.
    assign o_valid = (state_q != EMPTY);
    assign o_ready = (state_q != FULL);
    assign push    = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d   = BUSY;
                        main_load = 1'b1;
                    end
                end
                BUSY: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = BUSY;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REG; k++)
            main_d[k] = main_from_skid ? skid_q[k] : i_data[k];
    end

    skid_lane_regs #(.DATA_WIDTH(DATA_WIDTH), .NUM_REG(NUM_REG)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .d     (main_d),
        .q     (o_data)
    );

    skid_lane_regs #(.DATA_WIDTH(DATA_WIDTH), .NUM_REG(NUM_REG)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (i_data),
        .q     (skid_q)
    );

`ifdef PIPE_SKID_STATS_EN
    // Saturating stall counter; flush deliberately leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_stall_cnt <= '0;
        else if (o_valid && !i_ready && (o_stall_cnt != {STALL_CNT_W{1'b1}}))
            o_stall_cnt <= o_stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage against a two-deep FIFO queue model.
// Stall counter checks are compiled in with PIPE_SKID_STATS_EN.
module tb_pipe_skid_stage;

    localparam int DW = 8;
    localparam int NR = 6;
    localparam int WW = DW * NR;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data [NR];
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data [NR];
`ifdef PIPE_SKID_STATS_EN
    logic [15:0]   o_stall_cnt;
    int            m_stall = 0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [WW-1:0] mq [$];

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_WIDTH(DW), .NUM_REG(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
`ifdef PIPE_SKID_STATS_EN
        .o_stall_cnt (o_stall_cnt),
`endif
        .o_data      (o_data)
    );

    function automatic logic [WW-1:0] pack_out();
        logic [WW-1:0] w;
        for (int k = 0; k < NR; k++) w[k*DW +: DW] = o_data[k];
        return w;
    endfunction

    function automatic logic [WW-1:0] lanes(input logic [7:0] base, input logic [7:0] step);
        logic [WW-1:0] w;
        for (int k = 0; k < NR; k++) w[k*DW +: DW] = base + step * k[7:0];
        return w;
    endfunction

    // Drive one cycle at the negedge, check outputs against the model, then
    // advance the model across the following rising edge.
    task automatic cycle(input logic v, input logic [WW-1:0] d, input logic r, input logic f);
        logic do_pop, do_push;
        i_valid = v;
        i_ready = r;
        i_flush = f;
        for (int k = 0; k < NR; k++) i_data[k] = d[k*DW +: DW];
        n_cmp++;
        if (o_valid !== (mq.size() > 0)) begin
            n_err++;
            $display("FAIL o_valid: got %b want %b", o_valid, mq.size() > 0);
        end
        n_cmp++;
        if (o_ready !== (mq.size() < 2)) begin
            n_err++;
            $display("FAIL o_ready: got %b want %b", o_ready, mq.size() < 2);
        end
        if (mq.size() > 0) begin
            n_cmp++;
            if (pack_out() !== mq[0]) begin
                n_err++;
                $display("FAIL o_data: got %h want %h", pack_out(), mq[0]);
            end
        end
`ifdef PIPE_SKID_STATS_EN
        n_cmp++;
        if (o_stall_cnt !== m_stall[15:0]) begin
            n_err++;
            $display("FAIL stall_cnt: got %0d want %0d", o_stall_cnt, m_stall);
        end
        if (mq.size() > 0 && !r && m_stall < 16'hFFFF) m_stall++;
`endif
        do_pop  = (mq.size() > 0) && r;
        do_push = v && (mq.size() < 2);
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        rst_n   = 1'b0;
        mq.delete();
`ifdef PIPE_SKID_STATS_EN
        m_stall = 0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < NR; k++) i_data[k] = 8'h5A;
        apply_reset();
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hs: got v=%b r=%b want v=0 r=1", o_valid, o_ready);
        end
        n_cmp++;
        if (pack_out() !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", pack_out());
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_stream();
        cycle(1'b1, lanes(8'hAA, 8'h11), 1'b1, 1'b0);
        cycle(1'b1, lanes(8'h11, 8'h11), 1'b1, 1'b0);
        n_cmp++;
        if (pack_out() !== lanes(8'h11, 8'h11) || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stream_second: got %h r=%b want %h r=1", pack_out(), o_ready, lanes(8'h11, 8'h11));
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_back_pressure();
        cycle(1'b1, lanes(8'hA0, 8'h01), 1'b0, 1'b0);
        cycle(1'b1, lanes(8'hB0, 8'h01), 1'b0, 1'b0);
        n_cmp++;
        if (o_ready !== 1'b0 || pack_out() !== lanes(8'hA0, 8'h01)) begin
            n_err++;
            $display("FAIL bp_full: got r=%b d=%h want r=0 d=%h", o_ready, pack_out(), lanes(8'hA0, 8'h01));
        end
        cycle(1'b1, lanes(8'hC0, 8'h01), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: got r=%b v=%b want r=1 v=0", o_ready, o_valid);
        end
    endtask

    task automatic test_flush();
        cycle(1'b1, lanes(8'h30, 8'h02), 1'b0, 1'b0);
        cycle(1'b1, lanes(8'h40, 8'h02), 1'b0, 1'b0);
        cycle(1'b1, lanes(8'h50, 8'h02), 1'b1, 1'b1);
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_hs: got v=%b r=%b want v=0 r=1", o_valid, o_ready);
        end
        cycle(1'b1, lanes(8'h60, 8'h02), 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, lanes(8'h70, 8'h02), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        cycle(1'b1, lanes(8'h80, 8'h03), 1'b0, 1'b0);
        cycle(1'b1, lanes(8'h90, 8'h03), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || pack_out() !== '0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b r=%b d=%h want v=0 r=1 d=0", o_valid, o_ready, pack_out());
        end
        mq.delete();
`ifdef PIPE_SKID_STATS_EN
        m_stall = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom % 10) < 7, {$urandom, $urandom}, ($urandom % 10) < 6,
                  ($urandom % 40) == 0);
        end
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

`ifdef PIPE_SKID_STATS_EN
    task automatic test_stall_cnt();
        apply_reset();
        cycle(1'b1, lanes(8'hD0, 8'h01), 1'b0, 1'b0);
        repeat (5) cycle(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (o_stall_cnt !== 16'd5) begin
            n_err++;
            $display("FAIL stall_five: got %0d want 5", o_stall_cnt);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, lanes(8'hE0, 8'h01), 1'b0, 1'b0);
        repeat (65540) @(negedge clk);
        n_cmp++;
        if (o_stall_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL stall_sat: got %h want ffff", o_stall_cnt);
        end
        apply_reset();
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_random();
`ifdef PIPE_SKID_STATS_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
